// File: rtl/mmio_console_if.sv
// Core data-memory bus plus the byte stream toward the console consumer.
interface mmio_console_if;
  logic        DM_enable;
  logic        DM_read;
  logic        DM_write;
  logic [11:0] DM_address;
  logic [31:0] DM_in;
  logic [31:0] DM_out;
  logic        hit;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport slave (
    input  DM_enable, DM_read, DM_write, DM_address, DM_in, tx_ready,
    output DM_out, hit, tx_valid, tx_data
  );

  modport master (
    output DM_enable, DM_read, DM_write, DM_address, DM_in, tx_ready,
    input  DM_out, hit, tx_valid, tx_data
  );
endinterface

// File: rtl/mmio_console.sv
// Memory-mapped console: four word registers (TXDATA, STATUS, CYCLE, CTRL)
// feeding a byte TX FIFO drained over a valid/ready stream.
module mmio_console #(
  parameter logic [11:0] BASE  = 12'hF00,
  parameter int          DEPTH = 8
) (
  input logic            clk,
  input logic            rst,
  mmio_console_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [31:0]   dm_out_q, dm_out_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          drain_en_q, drain_en_d;
  logic          drop_q, drop_d;

  logic [1:0] off;
  logic       wr_en, rd_en, tx_wr, push, pop, full, empty, tx_valid;
  logic [31:0] status;

  assign off      = bus.DM_address[1:0];
  assign bus.hit  = bus.DM_enable && (bus.DM_address[11:2] == BASE[11:2]);
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign tx_valid = !empty && drain_en_q;
  assign status   = {16'b0, 8'(count_q), 6'b0, full, empty};

  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_data_q;
  assign bus.DM_out   = dm_out_q;

  always_comb begin
    // Read+write together is a write; the read half is dropped.
    wr_en = bus.hit && bus.DM_write;
    rd_en = bus.hit && bus.DM_read && !bus.DM_write;
    pop   = tx_valid && bus.tx_ready;
    tx_wr = wr_en && (off == 2'd0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push  = tx_wr && (!full || pop);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    // Head register: bypass the incoming byte when it becomes the new head.
    tx_data_d = tx_data_q;
    if (count_d != '0)
      tx_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? bus.DM_in[7:0] : mem_q[rd_ptr_d];

    cycle_d    = (wr_en && off == 2'd2) ? bus.DM_in : cycle_q + 32'd1;
    drain_en_d = drain_en_q;
    drop_d     = drop_q || (tx_wr && full && !pop);
    if (wr_en && off == 2'd3) begin
      drain_en_d = bus.DM_in[0];
      if (bus.DM_in[1]) drop_d = 1'b0;
    end

    dm_out_d = dm_out_q;
    if (rd_en) begin
      unique case (off)
        2'd0:    dm_out_d = 32'd0;
        2'd1:    dm_out_d = status;
        2'd2:    dm_out_d = cycle_q;
        default: dm_out_d = {30'd0, drop_q, drain_en_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      dm_out_q   <= '0;
      cycle_q    <= '0;
      drain_en_q <= 1'b1;
      drop_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      dm_out_q   <= dm_out_d;
      cycle_q    <= cycle_d;
      drain_en_q <= drain_en_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is not reset; count/pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= bus.DM_in[7:0];
  end
endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: register map, FIFO fill/drain, CYCLE wrap, reset.
module tb_mmio_console;
  localparam logic [11:0] TXD = 12'hF00, STA = 12'hF01, CYC = 12'hF02, CTL = 12'hF03;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] drained[$];
  logic [7:0] exp_q[$];

  mmio_console_if bus();
  mmio_console #(.BASE(12'hF00), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Record every byte transferred; inputs only change just after posedge.
  always @(negedge clk)
    if (!rst && bus.tx_valid && bus.tx_ready) drained.push_back(bus.tx_data);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.DM_enable = 1'b0; bus.DM_read = 1'b0; bus.DM_write = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.DM_enable = 1'b1; bus.DM_write = 1'b1; bus.DM_read = 1'b0;
    bus.DM_address = a; bus.DM_in = d;
    cyc(); idle();
  endtask

  task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.DM_enable = 1'b1; bus.DM_read = 1'b1; bus.DM_write = 1'b0; bus.DM_address = a;
    cyc(); idle();
    chk(tag, bus.DM_out, exp);
  endtask

  task automatic drain();
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 40 && bus.tx_valid; k++) cyc();
    chk("drain_done", {31'd0, bus.tx_valid}, 32'd0);
    bus.tx_ready = 1'b0;
  endtask

  task automatic qchk(input string tag);
    chk({tag, "_len"}, drained.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < drained.size(); i++)
      chk(tag, {24'd0, drained[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    idle(); bus.DM_address = '0; bus.DM_in = '0; bus.tx_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_dm_out", bus.DM_out, 32'd0);
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    rdchk("status_reset", STA, 32'h1);
    rdchk("ctrl_reset", CTL, 32'h1);

    // Three bytes streamed straight through with the consumer ready.
    bus.tx_ready = 1'b1; drained.delete();
    wr(TXD, 32'h41);
    chk("stream_v0", {31'd0, bus.tx_valid}, 32'd1);
    chk("stream_d0", {24'd0, bus.tx_data}, 32'h41);
    wr(TXD, 32'h42);
    chk("stream_d1", {24'd0, bus.tx_data}, 32'h42);
    wr(TXD, 32'h43);
    chk("stream_d2", {24'd0, bus.tx_data}, 32'h43);
    cyc();
    chk("stream_empty", {31'd0, bus.tx_valid}, 32'd0);
    rdchk("stream_status", STA, 32'h1);
    exp_q = '{8'h41, 8'h42, 8'h43};
    qchk("stream_order");

    // Overfill: the ninth byte is dropped and flagged.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(TXD, i);
    rdchk("full_status", STA, 32'h802);
    rdchk("full_ctrl", CTL, 32'h3);
    wr(CTL, 32'h3);
    rdchk("sticky_clr", CTL, 32'h1);
    rdchk("full_count_kept", STA, 32'h802);

    // Push and pop together while full.
    drained.delete();
    bus.tx_ready = 1'b1;
    wr(TXD, 32'h55);
    bus.tx_ready = 1'b0;
    rdchk("pp_status", STA, 32'h802);
    rdchk("pp_sticky", CTL, 32'h1);
    drain();
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h55};
    qchk("full_order");

    // CYCLE load then wrap.
    wr(CYC, 32'hFFFF_FFFE);
    rdchk("cyc_load", CYC, 32'hFFFF_FFFE);
    rdchk("cyc_max", CYC, 32'hFFFF_FFFF);
    rdchk("cyc_wrap", CYC, 32'h0);

    // drain_en gating; the head byte survives a disable.
    wr(CTL, 32'h0);
    wr(TXD, 32'hA1); wr(TXD, 32'hA2); wr(TXD, 32'hA3);
    chk("gated_valid", {31'd0, bus.tx_valid}, 32'd0);
    rdchk("gated_status", STA, 32'h300);
    wr(CTL, 32'h1);
    chk("ungated_valid", {31'd0, bus.tx_valid}, 32'd1);
    chk("ungated_head", {24'd0, bus.tx_data}, 32'hA1);
    wr(CTL, 32'h0);
    chk("regated_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("regated_head", {24'd0, bus.tx_data}, 32'hA1);
    rdchk("regated_status", STA, 32'h300);
    wr(CTL, 32'h1);
    drained.delete();
    drain();
    exp_q = '{8'hA1, 8'hA2, 8'hA3};
    qchk("gate_order");

    // Mid-cycle reset discards the FIFO and restores defaults.
    for (int i = 0; i < 4; i++) wr(TXD, 32'hB0 + i);
    chk("pre_rst_valid", {31'd0, bus.tx_valid}, 32'd1);
    rdchk("pre_rst_status", STA, 32'h400);
    wr(CTL, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dm_out", bus.DM_out, 32'd0);
    chk("mid_rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    #2 rst = 1'b0;
    rdchk("post_rst_status", STA, 32'h1);
    rdchk("post_rst_cycle", CYC, 32'h1);
    rdchk("post_rst_ctrl", CTL, 32'h1);
    chk("post_rst_valid", {31'd0, bus.tx_valid}, 32'd0);

    // Out-of-window accesses are ignored.
    bus.DM_enable = 1'b1; bus.DM_read = 1'b1; bus.DM_address = 12'hF04;
    #1 chk("miss_hi_hit", {31'd0, bus.hit}, 32'd0);
    cyc(); idle();
    chk("miss_hi_dm_out", bus.DM_out, 32'h1);
    bus.DM_enable = 1'b1; bus.DM_write = 1'b1; bus.DM_address = 12'hEFF; bus.DM_in = 32'h0;
    #1 chk("miss_lo_hit", {31'd0, bus.hit}, 32'd0);
    cyc(); idle();
    rdchk("miss_lo_ctrl", CTL, 32'h1);
    wr(12'hF04, 32'h77);
    rdchk("miss_no_push", STA, 32'h1);
    bus.DM_enable = 1'b0; bus.DM_address = CTL;
    #1 chk("no_enable_hit", {31'd0, bus.hit}, 32'd0);
    bus.DM_enable = 1'b1;
    #1 chk("base_hit", {31'd0, bus.hit}, 32'd1);
    idle();

    // Read+write is a write only.
    rdchk("ctrl_before_rw", CTL, 32'h1);
    bus.DM_enable = 1'b1; bus.DM_read = 1'b1; bus.DM_write = 1'b1;
    bus.DM_address = CYC; bus.DM_in = 32'h1234_5678;
    cyc(); idle();
    chk("rw_dm_out_held", bus.DM_out, 32'h1);
    rdchk("rw_cycle_loaded", CYC, 32'h1234_5678);
    rdchk("txdata_reads_zero", TXD, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_console.md
MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
REQ-001 Parameter BASE, 12'hF00: word address of register 0; BASE[1:0] SHALL be 2'b00.
REQ-002 Parameter DEPTH, 8: TX FIFO depth in bytes; SHALL be a power of 2 in the range 2..64.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 DM_enable  input  1  bus access strobe from the core.
REQ-006 DM_read  input  1  read request; qualified by DM_enable.
REQ-007 DM_write  input  1  write request; qualified by DM_enable.
REQ-008 DM_address  input  12  word address.
REQ-009 DM_in  input  32  write data.
REQ-010 DM_out  output  32  registered read data.
REQ-011 tx_valid  output  1  FIFO head byte is available to the consumer.
REQ-012 tx_data  output  8  FIFO head byte.
REQ-013 tx_ready  input  1  consumer accepts the byte when tx_valid && tx_ready on a rising edge.
REQ-014 hit  output  1  combinational; 1 when DM_enable && DM_address[11:2]==BASE[11:2].

Function
REQ-015 Register map SHALL decode on the offset DM_address[1:0]:
- 0 TXDATA: write only; reads return 0.
- 1 STATUS: read only; value = {16'b0, count[7:0], 6'b0, full, empty}.
- 2 CYCLE: 32-bit free-running counter.
- 3 CTRL: bit0 drain_en; bit1 drop_sticky (read-only, write-1-to-clear via DM_in[1]).
REQ-016 An access without hit SHALL be ignored, and DM_out SHALL hold its previous value.
REQ-017 A read with hit SHALL load DM_out on the same edge, giving 1-cycle latency in the same timing as the data memory.
REQ-018 DM_read && DM_write both asserted with hit SHALL be treated as a write only; DM_out SHALL be unchanged.
REQ-019 A TXDATA write SHALL push DM_in[7:0] when the FIFO is not full.
REQ-020 A TXDATA write when the FIFO is full SHALL discard the byte and set drop_sticky; count SHALL be unchanged.
REQ-021 A pop SHALL occur when tx_valid && tx_ready.
REQ-022 tx_valid SHALL equal !empty && drain_en; tx_data SHALL be the head byte, registered from FIFO storage.
REQ-023 Push and pop on the same edge:
- both occur and count is unchanged, including when full;
- a push into an empty FIFO is not visible on tx_valid until the next cycle.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-025 count SHALL saturate its range at 0..DEPTH, with full = (count==DEPTH) and empty = (count==0).
REQ-026 CYCLE SHALL increment by 1 every cycle and wrap from 32'hFFFFFFFF to 0.
REQ-027 A CYCLE write SHALL load DM_in; the loaded value SHALL be visible on the following cycle, and that write edge SHALL not also increment.
REQ-028 A CYCLE read SHALL return the value before that edge's increment.
REQ-029 Clearing drain_en while tx_valid is high SHALL deassert tx_valid next cycle without loss of data; the head byte SHALL remain.
REQ-030 A STATUS read on the same edge as a push or pop SHALL return the pre-edge count and flags.

Reset
REQ-031 While rst is high, the following SHALL hold immediately and asynchronously:
- DM_out = 0, CYCLE = 0, drain_en = 1, drop_sticky = 0;
- FIFO pointers and count = 0, tx_valid = 0, tx_data = 0.
REQ-032 Reset mid-operation SHALL discard all FIFO contents.
REQ-033 No push, pop, or register write SHALL take effect on an edge while rst is high.
REQ-034 FIFO storage array contents need not be reset.

Verification
REQ-035 After reset release, write TXDATA 0x41, 0x42, 0x43 with tx_ready=1 -> tx_data 0x41, 0x42, 0x43 on consecutive valid cycles; then STATUS read = 0x1.
REQ-036 With tx_ready=0, write DEPTH+1 bytes 0x00..0x08 -> STATUS = {count=8, full=1}; CTRL read bit1 = 1; drained order 0x00..0x07; byte 0x08 is absent.
REQ-037 With FIFO full and tx_ready=1, push 0x55 on the same edge as a pop -> count stays 8 and drop_sticky stays 0; 0x55 is drained last.
REQ-038 Write CYCLE = 32'hFFFFFFFE, then read at the next two edges -> 0xFFFFFFFE and 0xFFFFFFFF; the following read returns 0x00000000.
REQ-039 Write CTRL=0, push 3 bytes -> tx_valid=0; then write CTRL=1 -> tx_valid=1 next cycle.
REQ-040 Load 4 bytes, assert rst for 3 ns mid-cycle -> tx_valid=0 and STATUS=0x1 after release.
REQ-041 Access at BASE+4 or BASE-1 -> hit=0; DM_out unchanged; no state change.
